// File: rtl/pdm_tx_pkg.sv
// Shared widths and constants for the PDM audio transmit path.
package pdm_tx_pkg;

  localparam int unsigned PCM_W      = 16;
  localparam int unsigned ACC_W      = 17;
  localparam int unsigned UNDERRUN_W = 8;

  typedef logic [PCM_W-1:0] pcm_t;

  localparam pcm_t OFFSET = 16'h8000;

  // Signed two's complement to offset binary: -32768 -> 0, 0 -> 0x8000, 32767 -> 0xFFFF.
  function automatic pcm_t to_offset(pcm_t sample);
    return sample ^ OFFSET;
  endfunction

endpackage

// File: rtl/pdm_audio_tx_if.sv
// PCM sample stream with valid/ready handshake.
interface pdm_audio_tx_if;
  import pdm_tx_pkg::*;

  pcm_t s_data;
  logic s_valid;
  logic s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; DEPTH must be a power of two.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/pdm_audio_tx.sv
// PCM-to-PDM transmitter: sample FIFO, bit-clock divider and first-order sigma-delta modulator.
module pdm_audio_tx
  import pdm_tx_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 32,
  parameter int unsigned OSR        = 64,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned FILL_W    = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  pdm_audio_tx_if.slave         s,
  output logic                  pdm_data_o,
  output logic                  pdm_clk_o,
  output logic                  pdm_sd_o,
  output logic                  underrun,
  output logic [UNDERRUN_W-1:0] underrun_cnt,
  output logic [FILL_W-1:0]     fill
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned SMP_W = $clog2(OSR);

  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [SMP_W-1:0]      smp_cnt_q, smp_cnt_d;
  pcm_t                  acc_q, cur_sample_q, sample;
  logic [ACC_W-1:0]      acc17;
  logic                  pdm_data_q, pdm_clk_q, pdm_clk_d, pdm_sd_q, underrun_q;
  logic [UNDERRUN_W-1:0] underrun_cnt_q;
  logic                  tick, load, push;
  logic                  fifo_full, fifo_empty;
  pcm_t                  fifo_rdata;

  assign s.s_ready = reset_n && !fifo_full;
  assign push      = s.s_valid && s.s_ready;

  sync_fifo #(
    .WIDTH (PCM_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (load),
    .wdata   (s.s_data),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fill)
  );

  always_comb begin
    tick      = en && (div_cnt_q == DIV_W'(CLK_DIV - 1));
    load      = tick && (smp_cnt_q == '0);
    div_cnt_d = '0;
    if (en && !tick) div_cnt_d = div_cnt_q + DIV_W'(1);
    smp_cnt_d = smp_cnt_q;
    if (!en) begin
      smp_cnt_d = '0;
    end else if (tick) begin
      smp_cnt_d = (smp_cnt_q == SMP_W'(OSR - 1)) ? '0 : smp_cnt_q + SMP_W'(1);
    end
    // An empty FIFO at load time plays silence (PCM zero) rather than stalling the stream.
    sample    = load ? (fifo_empty ? '0 : fifo_rdata) : cur_sample_q;
    acc17     = {1'b0, acc_q} + {1'b0, to_offset(sample)};
    pdm_clk_d = en && (div_cnt_d < DIV_W'(CLK_DIV / 2));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt_q      <= '0;
      smp_cnt_q      <= '0;
      acc_q          <= '0;
      cur_sample_q   <= '0;
      pdm_data_q     <= 1'b0;
      pdm_clk_q      <= 1'b0;
      pdm_sd_q       <= 1'b0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      smp_cnt_q  <= smp_cnt_d;
      pdm_clk_q  <= pdm_clk_d;
      pdm_sd_q   <= en;
      underrun_q <= load && fifo_empty;
      if (load && fifo_empty && (underrun_cnt_q != '1)) begin
        underrun_cnt_q <= underrun_cnt_q + UNDERRUN_W'(1);
      end
      if (!en) begin
        acc_q        <= '0;
        cur_sample_q <= '0;
        pdm_data_q   <= 1'b0;
      end else if (tick) begin
        acc_q      <= acc17[PCM_W-1:0];
        pdm_data_q <= acc17[ACC_W-1];
        if (load) cur_sample_q <= sample;
      end
    end
  end

  assign pdm_data_o   = pdm_data_q;
  assign pdm_clk_o    = pdm_clk_q;
  assign pdm_sd_o     = pdm_sd_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = underrun_cnt_q;

endmodule

// File: doc/pdm_audio_tx.md
# pdm_audio_tx

Transmit-side counterpart of the microphone PDM receive path: accepts signed 16-bit PCM samples over a valid/ready handshake, buffers them in a small FIFO, and converts them to a 1-bit pulse-density-modulated stream with a first-order sigma-delta modulator. It drives the Nexys4 DDR mono audio amplifier (ampPWM/ampSD pins), runs on the 100 MHz system clock, and generates its own PDM bit clock by division.

## Interface
Parameters:
- CLK_DIV, 32 — system clocks per PDM bit (3.125 MHz at 100 MHz); even, ≥4.
- OSR, 64 — PDM bits per PCM sample (48.83 kHz sample rate at defaults); ≥2.
- FIFO_DEPTH, 4 — sample buffer entries; power of two.

Ports:
- clk  in  1  system clock (100 MHz); all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- en  in  1  modulator enable; low = idle, amplifier shut down.
- s_data  in  16  signed two's-complement PCM sample.
- s_valid  in  1  s_data valid.
- s_ready  out  1  FIFO can accept; transfer when s_valid && s_ready.
- pdm_data_o  out  1  PDM bit stream to amplifier.
- pdm_clk_o  out  1  PDM bit clock, 50% duty (debug/external DAC).
- pdm_sd_o  out  1  amplifier shutdown_n; high only while enabled.
- underrun  out  1  one-cycle pulse when a sample load finds FIFO empty.
- underrun_cnt  out  8  saturating count of underruns since reset.
- fill  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Divider div_cnt 0..CLK_DIV-1 advances while en=1; bit tick when div_cnt==CLK_DIV-1.
- Sample counter smp_cnt 0..OSR-1 advances on each bit tick; load event = bit tick with smp_cnt==0.
- On load: pop FIFO head into cur_sample; if FIFO empty, load MIDSCALE-equivalent zero (PCM 0x0000), pulse underrun, increment underrun_cnt (saturate at 255).
- Modulator, per bit tick: u = sample ^ 16'h8000 (offset binary), where sample = newly loaded value on a load tick, else cur_sample. acc17 = {1'b0, acc[15:0]} + u; pdm bit = acc17[16]; acc <= acc17[15:0]. Bit density = u/65536.
- FIFO: push on s_valid && s_ready; s_ready = !full. No bypass: push and load in the same cycle with FIFO empty → underrun; pushed word stays for next load. Push and pop same cycle with FIFO non-empty/non-full → fill unchanged.
- en low: div_cnt, smp_cnt, acc cleared to 0; pdm_data_o, pdm_clk_o, pdm_sd_o held 0; FIFO keeps accepting until full, no pops. en high: counting restarts from 0; first load occurs on first bit tick.
- en deasserted mid-sample: cur_sample discarded; next enable loads a fresh FIFO entry.

## Timing
- Reset (reset_n=0 at a clk edge): all counters, acc, cur_sample, FIFO pointers, underrun_cnt → 0; pdm_data_o, pdm_clk_o, pdm_sd_o, underrun → 0; fill → 0; s_ready forced 0 while reset_n low, 1 the cycle after release.
- All outputs except s_ready are registered; s_ready combinational from FIFO count (and reset_n).
- pdm_data_o updates the cycle after the bit tick; pdm_clk_o registered high for div_cnt_next in [0, CLK_DIV/2-1], so pdm_data_o changes coincident with pdm_clk_o rising.
- pdm_sd_o = en delayed by one register.
- underrun pulses in the cycle after the failing load tick, aligned with the pdm_data_o update.
- Sample-in to first PDM bit: ≤ CLK_DIV·OSR + 1 cycles when FIFO is empty and enabled.

## Structure
- Package pdm_tx_pkg: PCM_W=16, ACC_W=17, OFFSET=16'h8000, underrun counter width 8.
- Sub-module sync_fifo (parameterised width/depth, push/pop/full/empty/count), reusable for other sample paths.
- Top of block: divider, sample counter, modulator, underrun logic.

## Test plan
- Constant 0x7FFF, en=1, FIFO kept fed → over 65536 bits exactly 65535 ones; pdm_clk_o period 32 cycles.
- Constant 0x0000 → pattern 0,1,0,1…; constant 0x8000 → all zeros.
- Fill FIFO with 4 samples, en=0 → s_ready=0, fill=4, fifth s_valid held without transfer; en=1 → first pop at first bit tick, fill=3.
- Never push, en=1 → underrun pulse every 2048 cycles, underrun_cnt saturates at 255 after 255 loads, pdm stream alternates 0/1.
- Push and load on same cycle with FIFO empty → underrun=1, fill=1 afterward, next load uses the pushed word.
- Assert reset_n=0 mid-stream with FIFO at 3 → next cycle all outputs 0, fill=0, underrun_cnt=0; en drop mid-sample → pdm_sd_o low one cycle later, pdm_data_o 0.
